edge_event_scheduler: RTL and testbench



---
 rtl/edge_event_scheduler.sv | 157 +++++++++++++++
 tb/tb_edge_event_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler: latches per-channel event pulses and serves them round-robin over
// a req/ack handshake with a 1 ms-tick holdoff. Optional ack watchdog: EVT_SCHED_ACK_WDT_EN.
module edge_event_scheduler #(
  parameter int NUM_CH         = 8,
  parameter int HOLDOFF_W      = 16,
  parameter int ACK_TIMEOUT_MS = 100,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iTick_1ms,
  input  logic [NUM_CH-1:0]    iEvent,
  input  logic [NUM_CH-1:0]    iMask,
  input  logic [HOLDOFF_W-1:0] iHoldoff_ms,
  input  logic                 iClear,
  input  logic                 iAck,
  output logic                 oReq,
  output logic [CH_W-1:0]      oCh_id,
  output logic [NUM_CH-1:0]    oPending,
  output logic [NUM_CH-1:0]    oOverflow,
  output logic                 oTimeout
);

  // state | meaning
  // IDLE  | no grant; picks the next pending channel at or after rr_ptr
  // GRANT | oReq high on ch_q, waiting for iAck (or watchdog expiry)
  // HOLD  | post-service holdoff, counter decremented on iTick_1ms
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_e;

  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  state_e                state_q;
  logic                  req_q;
  logic                  timeout_q;
  logic [CH_W-1:0]       ch_q;
  logic [CH_W-1:0]       rr_q;
  logic [HOLDOFF_W-1:0]  cnt_q;
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     ovf_q, ovf_d;

  logic [NUM_CH-1:0]     set_v;
  logic [NUM_CH-1:0]     ack_clr;
  logic [CH_W-1:0]       ch_next;
  logic [CH_W-1:0]       sel_ch;
  logic [CH_W:0]         sum_c;
  logic                  sel_found;
  logic                  wdt_expire;

  assign ch_next = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);

  // A new event on the channel being acked re-arms it instead of counting as overflow.
  always_comb begin
    set_v   = iEvent & ~iMask;
    ack_clr = '0;
    if (state_q == S_GRANT && iAck) ack_clr[ch_q] = 1'b1;
    pend_d  = (pend_q & ~ack_clr) | set_v;
    ovf_d   = ovf_q | (set_v & pend_q & ~ack_clr);
  end

  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    sum_c     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_c = {1'b0, rr_q} + (CH_W + 1)'(k);
      if (sum_c >= NUM_CH_L) sum_c = sum_c - NUM_CH_L;
      if (!sel_found && pend_q[sum_c[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = sum_c[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      ch_q      <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
    end else if (iClear) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            state_q <= S_GRANT;
            req_q   <= 1'b1;
            ch_q    <= sel_ch;
          end
        end
        S_GRANT: begin
          if (iAck) begin
            req_q   <= 1'b0;
            rr_q    <= ch_next;
            cnt_q   <= iHoldoff_ms;
            state_q <= (iHoldoff_ms == '0) ? S_IDLE : S_HOLD;
          end else if (wdt_expire) begin
            req_q     <= 1'b0;
            rr_q      <= ch_next;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else if (iTick_1ms) begin
            cnt_q <= cnt_q - HOLDOFF_W'(1);
            if (cnt_q == HOLDOFF_W'(1)) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef EVT_SCHED_ACK_WDT_EN
  localparam int WDT_W = $clog2(ACK_TIMEOUT_MS + 1);
  logic [WDT_W-1:0] wdt_q;

  // Reloaded while idle so every grant starts with a full timeout window.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wdt_q <= '0;
    end else if (state_q == S_IDLE) begin
      wdt_q <= WDT_W'(ACK_TIMEOUT_MS);
    end else if (state_q == S_GRANT && iTick_1ms && wdt_q != '0) begin
      wdt_q <= wdt_q - WDT_W'(1);
    end
  end

  assign wdt_expire = (state_q == S_GRANT) && iTick_1ms && (wdt_q == WDT_W'(1));
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = (ACK_TIMEOUT_MS > 0);
  assign wdt_expire     = 1'b0;
`endif

  assign oReq      = req_q;
  assign oCh_id    = ch_q;
  assign oPending  = pend_q;
  assign oOverflow = ovf_q;
  assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: directed scenarios plus random traffic checked
// against a cycle-level reference model of the scheduling rules.
module tb_edge_event_scheduler;
  localparam int NUM_CH = 8;
  localparam int HW     = 16;
  localparam int TB_TO  = 2;
  localparam int CW     = $clog2(NUM_CH);

  logic              iClk = 1'b0;
  logic              iRst = 1'b1;
  logic              iTick_1ms = 1'b0;
  logic [NUM_CH-1:0] iEvent = '0;
  logic [NUM_CH-1:0] iMask = '0;
  logic [HW-1:0]     iHoldoff_ms = '0;
  logic              iClear = 1'b0;
  logic              iAck = 1'b0;
  logic              oReq;
  logic [CW-1:0]     oCh_id;
  logic [NUM_CH-1:0] oPending;
  logic [NUM_CH-1:0] oOverflow;
  logic              oTimeout;

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int ticks_seen = 0;
  bit auto_tick  = 1'b0;

  // reference model
  bit              m_req, m_to, m_hold_on;
  int              m_ch, m_rr, m_hold_left, m_wdt_ticks;
  bit [NUM_CH-1:0] m_pend, m_ovf;

  edge_event_scheduler #(
    .NUM_CH(NUM_CH), .HOLDOFF_W(HW), .ACK_TIMEOUT_MS(TB_TO)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iTick_1ms(iTick_1ms), .iEvent(iEvent), .iMask(iMask),
    .iHoldoff_ms(iHoldoff_ms), .iClear(iClear), .iAck(iAck), .oReq(oReq), .oCh_id(oCh_id),
    .oPending(oPending), .oOverflow(oOverflow), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic model_step();
    bit [NUM_CH-1:0] set_b, keep;
    bit acked;
    int pick, idx;
    if (iRst) begin
      m_pend = '0; m_ovf = '0; m_rr = 0; m_ch = 0; m_req = 0; m_to = 0;
      m_hold_on = 0; m_hold_left = 0; m_wdt_ticks = 0;
      return;
    end
    m_to = 0;
    if (iClear) begin
      m_pend = '0; m_ovf = '0; m_req = 0; m_hold_on = 0; m_hold_left = 0;
      return;
    end
    set_b = iEvent & ~iMask;
    acked = m_req && iAck;
    keep  = m_pend;
    if (acked) keep[m_ch] = 1'b0;
    m_ovf = m_ovf | (set_b & keep);
    if (m_req) begin
      if (acked) begin
        m_req = 0;
        m_rr  = (m_ch + 1) % NUM_CH;
        if (iHoldoff_ms != 0) begin
          m_hold_on   = 1;
          m_hold_left = int'(iHoldoff_ms);
        end
      end
`ifdef EVT_SCHED_ACK_WDT_EN
      else if (iTick_1ms) begin
        m_wdt_ticks++;
        if (m_wdt_ticks == TB_TO) begin
          m_req = 0;
          m_to  = 1;
          m_rr  = (m_ch + 1) % NUM_CH;
        end
      end
`endif
    end else if (m_hold_on) begin
      if (iTick_1ms) begin
        m_hold_left--;
        if (m_hold_left == 0) m_hold_on = 0;
      end
    end else begin
      pick = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (m_rr + k) % NUM_CH;
        if (pick < 0 && m_pend[idx]) pick = idx;
      end
      if (pick >= 0) begin
        m_req = 1;
        m_ch = pick;
        m_wdt_ticks = 0;
      end
    end
    m_pend = keep | set_b;
  endtask

  task automatic tick();
    @(posedge iClk);
    if (iTick_1ms) ticks_seen++;
    model_step();
    #1;
    cyc++;
    if (auto_tick) iTick_1ms = (cyc % 10 == 0);
  endtask

  task automatic do_reset();
    iRst = 1; iEvent = '0; iMask = '0; iAck = 0; iClear = 0; iHoldoff_ms = '0;
    tick(); tick();
    iRst = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (oReq !== 1'b0) $display("FAIL reset_req: got %b want 0", oReq); else n_pass++;
    n_checks++; if (oCh_id !== '0) $display("FAIL reset_ch: got %0d want 0", oCh_id); else n_pass++;
    n_checks++; if (oPending !== '0) $display("FAIL reset_pend: got %h want 00", oPending); else n_pass++;
    n_checks++; if (oOverflow !== '0) $display("FAIL reset_ovf: got %h want 00", oOverflow); else n_pass++;
    n_checks++; if (oTimeout !== 1'b0) $display("FAIL reset_to: got %b want 0", oTimeout); else n_pass++;
    iEvent = 8'h02; tick(); iEvent = '0; tick();
    n_checks++; if (oReq !== 1'b1) $display("FAIL pre_reset_req: got %b want 1", oReq); else n_pass++;
    #2; iRst = 1; #1;
    n_checks++;
    if (oReq !== 1'b0 || oPending !== '0)
      $display("FAIL async_reset_drop: got req=%b pend=%h want req=0 pend=00", oReq, oPending);
    else n_pass++;
    tick(); iRst = 0; tick();
  endtask

  task automatic test_basic();
    do_reset();
    iEvent = 8'h04; tick(); iEvent = '0;
    n_checks++; if (oPending !== 8'h04) $display("FAIL basic_pend: got %h want 04", oPending); else n_pass++;
    n_checks++; if (oReq !== 1'b0) $display("FAIL basic_req_early: got %b want 0", oReq); else n_pass++;
    tick();
    n_checks++;
    if (oReq !== 1'b1 || oCh_id !== 3'd2) $display("FAIL basic_grant: got req=%b ch=%0d want req=1 ch=2", oReq, oCh_id);
    else n_pass++;
    tick(); tick();
    n_checks++; if (oCh_id !== 3'd2) $display("FAIL basic_ch_stable: got %0d want 2", oCh_id); else n_pass++;
    iAck = 1; iHoldoff_ms = '0; tick(); iAck = 0;
    n_checks++;
    if (oReq !== 1'b0 || oPending !== '0) $display("FAIL basic_ack: got req=%b pend=%h want 0/00", oReq, oPending);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    iEvent = 8'h81; tick(); iEvent = '0;
    n_checks++; if (oPending !== 8'h81) $display("FAIL rr_pend_both: got %h want 81", oPending); else n_pass++;
    tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd0) $display("FAIL rr_first: got req=%b ch=%0d want 1/0", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0;
    n_checks++; if (oReq !== 1'b0 || oPending !== 8'h80) $display("FAIL rr_ack0: got req=%b pend=%h want 0/80", oReq, oPending); else n_pass++;
    tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd7) $display("FAIL rr_second: got req=%b ch=%0d want 1/7", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0; tick();
    iEvent = 8'h82; tick(); iEvent = '0; tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd1) $display("FAIL rr_wrap: got req=%b ch=%0d want 1/1", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0; tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd7) $display("FAIL rr_wrap_next: got req=%b ch=%0d want 1/7", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0; tick();
  endtask

  task automatic test_holdoff();
    int t0;
    bit early, reached;
    do_reset();
    iEvent = 8'h03; tick(); iEvent = '0; tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd0) $display("FAIL hold_grant0: got req=%b ch=%0d want 1/0", oReq, oCh_id); else n_pass++;
    auto_tick = 1;
    iHoldoff_ms = 16'd3; iAck = 1; tick(); iAck = 0; iHoldoff_ms = '0;
    t0 = ticks_seen;
    early = 0;
    for (int i = 0; i < 80; i++) begin
      if (ticks_seen - t0 >= 3) break;
      if (oReq) early = 1;
      tick();
    end
    reached = (ticks_seen - t0 >= 3);
    if (oReq) early = 1;
    n_checks++; if (reached !== 1'b1) $display("FAIL hold_ticks_bound: got %0d ticks want 3", ticks_seen - t0); else n_pass++;
    n_checks++; if (early !== 1'b0) $display("FAIL hold_early_req: got early=%b want 0", early); else n_pass++;
    n_checks++; if (oPending !== 8'h02) $display("FAIL hold_pend: got %h want 02", oPending); else n_pass++;
    tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd1) $display("FAIL hold_release: got req=%b ch=%0d want 1/1", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0;
    auto_tick = 0; iTick_1ms = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    iEvent = 8'h20; tick(); tick(); iEvent = '0;
    n_checks++; if (oOverflow !== 8'h20) $display("FAIL ovf_set: got %h want 20", oOverflow); else n_pass++;
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd5) $display("FAIL ovf_grant: got req=%b ch=%0d want 1/5", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0;
    n_checks++;
    if (oOverflow !== 8'h20 || oPending !== '0) $display("FAIL ovf_sticky: got ovf=%h pend=%h want 20/00", oOverflow, oPending);
    else n_pass++;
    iMask = 8'h20; iEvent = 8'h20; tick(); iEvent = '0;
    n_checks++;
    if (oPending !== '0 || oOverflow !== 8'h20) $display("FAIL ovf_masked: got pend=%h ovf=%h want 00/20", oPending, oOverflow);
    else n_pass++;
    tick();
    n_checks++; if (oReq !== 1'b0) $display("FAIL ovf_masked_req: got %b want 0", oReq); else n_pass++;
    iMask = '0; iClear = 1; tick(); iClear = 0;
    n_checks++; if (oOverflow !== '0) $display("FAIL ovf_clear: got %h want 00", oOverflow); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    iEvent = 8'h04; tick(); iEvent = '0; tick();
    iAck = 1; iEvent = 8'h04; tick(); iAck = 0; iEvent = '0;
    n_checks++;
    if (oPending !== 8'h04 || oOverflow !== '0 || oReq !== 1'b0)
      $display("FAIL rearm_ack: got pend=%h ovf=%h req=%b want 04/00/0", oPending, oOverflow, oReq);
    else n_pass++;
    tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd2) $display("FAIL rearm_regrant: got req=%b ch=%0d want 1/2", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0;
  endtask

  task automatic test_clear();
    do_reset();
    iEvent = 8'h02; tick(); iEvent = '0; tick();
    iAck = 1; tick(); iAck = 0;
    iEvent = 8'h09; tick(); iEvent = '0; tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd3) $display("FAIL clr_grant3: got req=%b ch=%0d want 1/3", oReq, oCh_id); else n_pass++;
    iEvent = 8'h08; tick(); iEvent = '0;
    n_checks++; if (oOverflow !== 8'h08) $display("FAIL clr_pre_ovf: got %h want 08", oOverflow); else n_pass++;
    iClear = 1; iEvent = 8'h10; tick(); iClear = 0; iEvent = '0;
    n_checks++;
    if (oReq !== 1'b0 || oPending !== '0 || oOverflow !== '0)
      $display("FAIL clr_effect: got req=%b pend=%h ovf=%h want 0/00/00", oReq, oPending, oOverflow);
    else n_pass++;
    tick();
    n_checks++; if (oReq !== 1'b0) $display("FAIL clr_drop_evt: got req=%b want 0", oReq); else n_pass++;
    iEvent = 8'h06; tick(); iEvent = '0; tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd2) $display("FAIL clr_rr_kept: got req=%b ch=%0d want 1/2", oReq, oCh_id); else n_pass++;
    iAck = 1; tick(); iAck = 0;
  endtask

  task automatic test_watchdog();
    bit bad;
    do_reset();
    auto_tick = 1;
    iEvent = 8'h50; tick(); iEvent = '0; tick();
    n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd4) $display("FAIL wdt_grant4: got req=%b ch=%0d want 1/4", oReq, oCh_id); else n_pass++;
`ifdef EVT_SCHED_ACK_WDT_EN
    begin
      int gticks;
      bit seen, was_req, tk;
      gticks = 0; seen = 0;
      for (int i = 0; i < 100; i++) begin
        was_req = oReq; tk = iTick_1ms;
        tick();
        if (was_req && tk) gticks++;
        if (oTimeout) begin seen = 1; break; end
      end
      n_checks++; if (seen !== 1'b1 || gticks != TB_TO) $display("FAIL wdt_pulse: got seen=%b ticks=%0d want 1/%0d", seen, gticks, TB_TO); else n_pass++;
      n_checks++; if (oPending[4] !== 1'b1 || oReq !== 1'b0) $display("FAIL wdt_state: got pend4=%b req=%b want 1/0", oPending[4], oReq); else n_pass++;
      tick();
      n_checks++; if (oTimeout !== 1'b0) $display("FAIL wdt_single: got %b want 0", oTimeout); else n_pass++;
      n_checks++; if (oReq !== 1'b1 || oCh_id !== 3'd6) $display("FAIL wdt_next: got req=%b ch=%0d want 1/6", oReq, oCh_id); else n_pass++;
    end
`else
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (oReq !== 1'b1 || oTimeout !== 1'b0 || oCh_id !== 3'd4) bad = 1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL wdt_off_wait: got bad=%b want 0", bad); else n_pass++;
`endif
    iAck = 1; tick(); iAck = 0;
    auto_tick = 0; iTick_1ms = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NUM_CH; b++) iEvent[b] = ($urandom_range(0, 11) == 0);
      if (c % 100 == 0)
        for (int b = 0; b < NUM_CH; b++) iMask[b] = ($urandom_range(0, 3) == 0);
      iAck        = ($urandom_range(0, 3) == 0);
      iHoldoff_ms = HW'($urandom_range(0, 3));
      iTick_1ms   = ($urandom_range(0, 5) == 0);
      iClear      = ($urandom_range(0, 199) == 0);
      tick();
      n_checks++; if (oReq !== m_req) $display("FAIL rnd_req c=%0d: got %b want %b", c, oReq, m_req); else n_pass++;
      if (m_req) begin
        n_checks++; if (oCh_id !== CW'(m_ch)) $display("FAIL rnd_ch c=%0d: got %0d want %0d", c, oCh_id, m_ch); else n_pass++;
      end
      n_checks++; if (oPending !== m_pend) $display("FAIL rnd_pend c=%0d: got %h want %h", c, oPending, m_pend); else n_pass++;
      n_checks++; if (oOverflow !== m_ovf) $display("FAIL rnd_ovf c=%0d: got %h want %h", c, oOverflow, m_ovf); else n_pass++;
      n_checks++; if (oTimeout !== m_to) $display("FAIL rnd_to c=%0d: got %b want %b", c, oTimeout, m_to); else n_pass++;
    end
    iEvent = '0; iMask = '0; iAck = 0; iClear = 0; iTick_1ms = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_holdoff();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
